// File: rtl/image_tx_streamer_pkg.sv
// Shared types and constants for the transmit side of the image pipeline.
// Provides the pixel payload, the streamer state encoding and the
// frame/line marker bundle. Tx frame size is the rx frame with the
// processing border removed.
package image_tx_streamer_pkg;

    localparam int unsigned IMAGE_WIDTH   = 640;
    localparam int unsigned IMAGE_HEIGHT  = 480;
    localparam int unsigned CENTER_PIXEL  = 1;
    localparam int unsigned TX_WIDTH_DEF  = IMAGE_WIDTH - 2 * CENTER_PIXEL;
    localparam int unsigned TX_HEIGHT_DEF = IMAGE_HEIGHT - 2 * CENTER_PIXEL;
    localparam int unsigned COLOR_W       = 8;
    localparam int unsigned PIXEL_W       = 3 * COLOR_W;
    localparam int unsigned FRAME_CNT_W   = 16;

    typedef struct packed {
        logic [COLOR_W-1:0] red;
        logic [COLOR_W-1:0] green;
        logic [COLOR_W-1:0] blue;
    } pixel_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } tx_state_t;

    typedef struct packed {
        logic sof;
        logic eol;
        logic eof;
    } tx_markers_t;

endpackage

// File: rtl/image_tx_streamer_fifo.sv
// tx_pixel_fifo: small synchronous FIFO of pixel_t with flush.
// Ports: clk, rst_n (async, active low), flush (drop all entries),
// push/din (write), pop (read), full, empty, dout (head entry, show-ahead).
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module tx_pixel_fifo
    import image_tx_streamer_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   flush,
    input  logic   push,
    input  logic   pop,
    input  pixel_t din,
    output logic   full,
    output logic   empty,
    output pixel_t dout
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    pixel_t        mem [DEPTH];

    logic do_push;
    logic do_pop;

    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;

    // Pointer update; flush returns both pointers to the origin.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
        end
    end

    // Storage array, data only (no reset needed).
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign dout  = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/image_tx_streamer.sv
// image_tx_streamer: buffers result pixels and streams them out as a
// raster-ordered tx frame with SOF/EOL/EOF markers.
// Ports: clk, rstN (async active low); start/abort frame control;
// inValid/inReady/inPixel result input; txValid/txReady/txPixel and
// txSof/txEol/txEof output stream; busy, frameDone pulse, frameCount.
module image_tx_streamer
    import image_tx_streamer_pkg::*;
#(
    parameter int unsigned TX_WIDTH   = TX_WIDTH_DEF,
    parameter int unsigned TX_HEIGHT  = TX_HEIGHT_DEF,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rstN,
    input  logic                   start,
    input  logic                   abort,
    input  logic                   inValid,
    output logic                   inReady,
    input  logic [PIXEL_W-1:0]     inPixel,
    output logic                   txValid,
    input  logic                   txReady,
    output logic [PIXEL_W-1:0]     txPixel,
    output logic                   txSof,
    output logic                   txEol,
    output logic                   txEof,
    output logic                   busy,
    output logic                   frameDone,
    output logic [FRAME_CNT_W-1:0] frameCount
);

    localparam int unsigned COL_W = $clog2(TX_WIDTH);
    localparam int unsigned ROW_W = $clog2(TX_HEIGHT);
    localparam int unsigned CNT_W = $clog2(TX_WIDTH * TX_HEIGHT + 1);

    localparam logic [COL_W-1:0] COL_LAST  = COL_W'(TX_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(TX_HEIGHT - 1);
    localparam logic [CNT_W-1:0] PIX_TOTAL = CNT_W'(TX_WIDTH * TX_HEIGHT);

    tx_state_t        state;
    tx_state_t        state_next;
    logic             frame_clear;
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic [CNT_W-1:0] in_count;
    logic [FRAME_CNT_W-1:0] frame_count;
    logic             fifo_full;
    logic             fifo_empty;
    pixel_t           fifo_dout;
    pixel_t           in_pix;
    tx_markers_t      markers;
    logic             in_fire;
    logic             tx_fire;

    assign in_pix = inPixel;

    tx_pixel_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rstN),
        .flush (frame_clear),
        .push  (in_fire),
        .pop   (tx_fire),
        .din   (in_pix),
        .full  (fifo_full),
        .empty (fifo_empty),
        .dout  (fifo_dout)
    );

    // Input side closes once the whole frame has been accepted.
    assign inReady = (state == STREAM) && !fifo_full && (in_count != PIX_TOTAL);
    assign txValid = (state == STREAM) && !fifo_empty;
    assign txPixel = txValid ? fifo_dout : '0;
    assign in_fire = inValid && inReady;
    assign tx_fire = txValid && txReady;

    // Markers describe the FIFO head and are masked when nothing is presented.
    always_comb begin
        markers = '0;
        if (txValid) begin
            markers.sof = (col == '0) && (row == '0);
            markers.eol = (col == COL_LAST);
            markers.eof = (col == COL_LAST) && (row == ROW_LAST);
        end
    end

    assign txSof      = markers.sof;
    assign txEol      = markers.eol;
    assign txEof      = markers.eof;
    assign frameCount = frame_count;

    // State register.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) state <= IDLE;
        else       state <= state_next;
    end

    // Next state, frame clear (start or abort) and state-decoded outputs.
    always_comb begin
        state_next  = state;
        frame_clear = 1'b0;
        busy        = 1'b0;
        frameDone   = 1'b0;
        case (state)
            IDLE: begin
                if (start && !abort) begin
                    state_next  = STREAM;
                    frame_clear = 1'b1;
                end
            end
            STREAM: begin
                busy = 1'b1;
                if (abort) begin
                    state_next  = IDLE;
                    frame_clear = 1'b1;
                end else if (tx_fire && markers.eof) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                frameDone  = 1'b1;
                state_next = IDLE;
                if (abort) frame_clear = 1'b1;
            end
            default: state_next = IDLE;
        endcase
    end

    // Raster position of the FIFO head and accepted-pixel count.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            col      <= '0;
            row      <= '0;
            in_count <= '0;
        end else if (frame_clear) begin
            col      <= '0;
            row      <= '0;
            in_count <= '0;
        end else begin
            if (in_fire) in_count <= in_count + CNT_W'(1);
            if (tx_fire) begin
                if (col == COL_LAST) begin
                    col <= '0;
                    row <= (row == ROW_LAST) ? '0 : row + ROW_W'(1);
                end else begin
                    col <= col + COL_W'(1);
                end
            end
        end
    end

    // Completed-frame counter; an abort during DONE does not count the frame.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            frame_count <= '0;
        end else if ((state == DONE) && !abort) begin
            frame_count <= frame_count + FRAME_CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_image_tx_streamer.sv
// Self-checking bench for image_tx_streamer with a small 4x3 frame.
// Reference: queue of accepted pixels plus raster markers derived from the
// output index (k % W, k / W).
module tb_image_tx_streamer;

    localparam int W = 4;
    localparam int H = 3;
    localparam int D = 4;
    localparam int N = W * H;

    logic        clk = 1'b0;
    logic        rstN = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        inValid = 1'b0;
    logic        inReady;
    logic [23:0] inPixel = '0;
    logic        txValid;
    logic        txReady = 1'b0;
    logic [23:0] txPixel;
    logic        txSof;
    logic        txEol;
    logic        txEof;
    logic        busy;
    logic        frameDone;
    logic [15:0] frameCount;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] fc_exp = '0;

    image_tx_streamer #(
        .TX_WIDTH   (W),
        .TX_HEIGHT  (H),
        .FIFO_DEPTH (D)
    ) dut (
        .clk        (clk),
        .rstN       (rstN),
        .start      (start),
        .abort      (abort),
        .inValid    (inValid),
        .inReady    (inReady),
        .inPixel    (inPixel),
        .txValid    (txValid),
        .txReady    (txReady),
        .txPixel    (txPixel),
        .txSof      (txSof),
        .txEol      (txEol),
        .txEof      (txEof),
        .busy       (busy),
        .frameDone  (frameDone),
        .frameCount (frameCount)
    );

    always #5 clk = ~clk;

    task automatic check_idle_outputs(input string tag, input logic [15:0] fc);
        checks++;
        if ({inReady, txValid, txSof, txEol, txEof, busy, frameDone} !== 7'b0 ||
            txPixel !== 24'h0 || frameCount !== fc) begin
            errors++;
            $display("FAIL %s idle outputs got rdy=%b vld=%b pix=%h m=%b%b%b busy=%b done=%b fc=%0d exp all zero fc=%0d",
                     tag, inReady, txValid, txPixel, txSof, txEol, txEof, busy, frameDone, frameCount, fc);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL start_busy got %b exp 1", busy);
        end
    endtask

    // One frame under random handshakes; optional initial stall, abort or reset.
    task automatic run_frame(input string tag, input int valid_pct, input int ready_pct,
                             input bit seq, input int hold, input int abort_at,
                             input int reset_at, input bit start_noise);
        logic [23:0] expq[$];
        logic [23:0] nxt;
        logic [23:0] first_pix;
        int n_in = 0;
        int n_out = 0;
        int cyc = 0;
        bit exp_vld;
        bit exp_rdy;
        pulse_start();
        nxt = seq ? 24'd1 : 24'($urandom);
        first_pix = nxt;
        while (n_out < N && cyc < 400) begin
            @(negedge clk);
            if (cyc < hold) begin
                inValid = 1'b1;
                txReady = 1'b0;
            end else begin
                inValid = ($urandom_range(99) < valid_pct);
                txReady = ($urandom_range(99) < ready_pct);
            end
            inPixel = nxt;
            start = start_noise && ($urandom_range(99) < 15);
            #1;
            exp_vld = (expq.size() > 0);
            exp_rdy = (expq.size() < D) && (n_in < N);
            checks++;
            if (txValid !== exp_vld || inReady !== exp_rdy) begin
                errors++;
                $display("FAIL %s handshake cyc %0d got vld=%b rdy=%b exp vld=%b rdy=%b",
                         tag, cyc, txValid, inReady, exp_vld, exp_rdy);
            end
            checks++;
            if (busy !== 1'b1 || frameDone !== 1'b0 || frameCount !== fc_exp) begin
                errors++;
                $display("FAIL %s status got busy=%b done=%b fc=%0d exp 1 0 %0d",
                         tag, busy, frameDone, frameCount, fc_exp);
            end
            if (hold > 0 && cyc == hold) begin
                checks++;
                if (n_in != D || inReady !== 1'b0 || txPixel !== first_pix) begin
                    errors++;
                    $display("FAIL %s stall got accepted=%0d rdy=%b pix=%h exp %0d 0 %h",
                             tag, n_in, inReady, txPixel, D, first_pix);
                end
            end
            if (txValid === 1'b1 && expq.size() > 0) begin
                checks++;
                if (txPixel !== expq[0] || txSof !== (n_out == 0) ||
                    txEol !== ((n_out % W) == W - 1) || txEof !== (n_out == N - 1)) begin
                    errors++;
                    $display("FAIL %s out %0d got pix=%h sof=%b eol=%b eof=%b exp pix=%h sof=%b eol=%b eof=%b",
                             tag, n_out, txPixel, txSof, txEol, txEof, expq[0],
                             n_out == 0, (n_out % W) == W - 1, n_out == N - 1);
                end
                if (txReady) begin
                    void'(expq.pop_front());
                    n_out++;
                end
            end
            if (inValid && inReady) begin
                expq.push_back(nxt);
                n_in++;
                nxt = seq ? nxt + 24'd1 : 24'($urandom);
            end
            cyc++;
            if (abort_at >= 0 && n_out == abort_at) begin
                @(negedge clk);
                abort = 1'b1;
                start = 1'b0;
                inValid = 1'b0;
                txReady = 1'b0;
                @(negedge clk);
                abort = 1'b0;
                #1;
                check_idle_outputs({tag, "_abort"}, fc_exp);
                return;
            end
            if (reset_at >= 0 && n_in == reset_at) begin
                @(negedge clk);
                start = 1'b0;
                inValid = 1'b0;
                txReady = 1'b0;
                rstN = 1'b0;
                #1;
                fc_exp = '0;
                check_idle_outputs({tag, "_reset"}, fc_exp);
                @(negedge clk);
                rstN = 1'b1;
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk);
                    inValid = 1'b1;
                    txReady = 1'b1;
                    #1;
                    check_idle_outputs({tag, "_no_start"}, fc_exp);
                end
                inValid = 1'b0;
                return;
            end
        end
        if (n_out < N) begin
            checks++;
            errors++;
            $display("FAIL %s timeout got %0d outputs exp %0d", tag, n_out, N);
        end
        // Over-supply continues through DONE and IDLE.
        @(negedge clk);
        start = 1'b0;
        inValid = 1'b1;
        txReady = 1'b1;
        #1;
        checks++;
        if (frameDone !== 1'b1 || busy !== 1'b0 || inReady !== 1'b0 || txValid !== 1'b0) begin
            errors++;
            $display("FAIL %s done got done=%b busy=%b rdy=%b vld=%b exp 1 0 0 0",
                     tag, frameDone, busy, inReady, txValid);
        end
        fc_exp = fc_exp + 16'd1;
        @(negedge clk);
        #1;
        check_idle_outputs({tag, "_after"}, fc_exp);
        inValid = 1'b0;
        txReady = 1'b0;
    endtask

    task automatic test_reset();
        rstN = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check_idle_outputs("reset", 16'd0);
        @(negedge clk);
        rstN = 1'b1;
        @(negedge clk);
        start = 1'b0;
        inValid = 1'b1;
        #1;
        check_idle_outputs("idle_no_start", 16'd0);
        inValid = 1'b0;
    endtask

    task automatic test_basic();
        run_frame("basic", 100, 100, 1'b1, 0, -1, -1, 1'b0);
    endtask

    task automatic test_backpressure();
        run_frame("backpressure", 100, 100, 1'b1, 6, -1, -1, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 3; i++) run_frame("random", 60, 55, 1'b0, 0, -1, -1, 1'b0);
    endtask

    task automatic test_abort();
        run_frame("abort", 80, 80, 1'b1, 0, 5, -1, 1'b0);
        run_frame("after_abort", 100, 100, 1'b1, 0, -1, -1, 1'b0);
    endtask

    task automatic test_reset_mid();
        run_frame("reset_mid", 100, 50, 1'b1, 0, -1, 7, 1'b0);
        run_frame("after_reset", 100, 100, 1'b0, 0, -1, -1, 1'b0);
    endtask

    task automatic test_start_ignored();
        run_frame("start_ignored", 70, 70, 1'b0, 0, -1, -1, 1'b1);
    endtask

    task automatic test_wrap();
        @(negedge clk);
        force dut.frame_count = 16'hFFFF;
        @(negedge clk);
        release dut.frame_count;
        #1;
        fc_exp = 16'hFFFF;
        checks++;
        if (frameCount !== 16'hFFFF) begin
            errors++;
            $display("FAIL wrap_preload got %0d exp 65535", frameCount);
        end
        run_frame("wrap", 100, 100, 1'b1, 0, -1, -1, 1'b0);
        checks++;
        if (frameCount !== 16'd0) begin
            errors++;
            $display("FAIL wrap got %0d exp 0", frameCount);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_random();
        test_abort();
        test_reset_mid();
        test_start_ignored();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/image_tx_streamer.md
Name: image_tx_streamer

Overview:
- Transmit end of the image pipeline: accepts result pixels (pixel_t) from the cell processor one at a time and streams them out as a raster-ordered tx image with frame and line markers.
- Buffers results in a small FIFO, applies valid/ready backpressure on both sides, counts column and row, and signals frame completion.
- Mirror of the rx image path: the processor consumes rxImage_t frames and this block emits txImage_t-sized frames.

Parameters:
- TX_WIDTH, 638, pixels per output line (imageWidth - 2*centerPixel).
- TX_HEIGHT, 478, lines per output frame (imageHeighth - 2*centerPixel).
- FIFO_DEPTH, 4, result buffer entries; power of 2, >= 2.

Ports:
- clk  in  1  single clock, rising edge.
- rstN  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; arms a new frame when idle.
- abort  in  1  one-cycle pulse; drops the current frame.
- inValid  in  1  result pixel available.
- inReady  out  1  block accepts a result pixel this cycle.
- inPixel  in  24  result pixel_t {red, green, blue}.
- txValid  out  1  output pixel valid.
- txReady  in  1  downstream accepts output pixel.
- txPixel  out  24  output pixel_t.
- txSof  out  1  qualifies txValid; first pixel of frame (col 0, row 0).
- txEol  out  1  qualifies txValid; last pixel of a line (col TX_WIDTH-1).
- txEof  out  1  qualifies txValid; last pixel of frame.
- busy  out  1  high from accepted start until frame done or abort.
- frameDone  out  1  one-cycle pulse after the EOF pixel handshake.
- frameCount  out  16  completed frames, wraps at 65535 -> 0.

Behaviour:
- Reset values: inReady=0, txValid=0, txPixel=0, txSof/txEol/txEof=0, busy=0, frameDone=0, frameCount=0, FIFO empty, col=row=0, state=IDLE.
- Handshakes: input transfer when inValid && inReady; output transfer when txValid && txReady. Once txValid is raised, txPixel and the markers hold stable until transfer.
- FSM states:
  - IDLE: inReady=0; start -> STREAM; col=row=0; busy=1.
  - STREAM: inReady = !fifoFull. txValid = !fifoEmpty. After each output transfer, col increments; at TX_WIDTH-1, col wraps to 0 and row increments. The output transfer with col=TX_WIDTH-1 and row=TX_HEIGHT-1 -> DONE.
  - DONE: one cycle; frameDone=1, frameCount+1, busy=0, inReady=0 -> IDLE.
- Pixel acceptance: the block accepts exactly TX_WIDTH*TX_HEIGHT input pixels per frame. After the last input pixel is accepted, inReady=0 until the next frame starts (input-side counter).
- Markers are combinational from the col/row counters at the FIFO head:
  - txSof = (col==0 && row==0).
  - txEol = (col==TX_WIDTH-1).
  - txEof = txEol && (row==TX_HEIGHT-1).
- Latency: an input pixel accepted into an empty FIFO appears on txValid the next cycle (1-cycle latency). Sustained throughput is 1 pixel/cycle with txReady held high.
- FIFO boundaries:
  - Simultaneous push and pop when full: the pop frees space, but inReady is still computed from the registered full flag, so no push happens that cycle.
  - Simultaneous push and pop when empty: not possible, because txValid=0 when empty.
  - Pointers are log2(FIFO_DEPTH)+1 bits and wrap naturally.
- start is ignored outside IDLE.
- abort in STREAM or DONE: next cycle state=IDLE, FIFO flushed, counters cleared, busy=0, txValid=0, no frameDone, frameCount unchanged. abort in IDLE has no effect. abort and start in the same cycle: abort wins.
- Reset mid-frame clears everything asynchronously; no partial-frame markers are emitted afterwards.
- Width rules: col is $clog2(TX_WIDTH) bits, row is $clog2(TX_HEIGHT) bits, and the input pixel counter is $clog2(TX_WIDTH*TX_HEIGHT+1) bits. Pixel data is passed unmodified, with no arithmetic.

Decomposition:
- ImageProcessingPkg gains:
  - txWidth and txHeight constants derived from imageWidth, imageHeighth and centerPixel.
  - txState_t enum {IDLE, STREAM, DONE}.
  - txMarkers_t packed struct {sof, eol, eof}.
- pixel_t is imported from CellProcessingPkg.
- Sub-module tx_pixel_fifo: synchronous FIFO of pixel_t with parameter DEPTH and ports push, pop, full, empty, dout. It is reusable on the rx side.

Test Plan (TX_WIDTH=4, TX_HEIGHT=3, FIFO_DEPTH=4):
- Basic frame: start, then 12 pixels 0x000001..0x00000C with txReady=1. Required: 12 outputs in order; txSof on 0x000001; txEol on 0x000004, 0x000008 and 0x00000C; txEof on 0x00000C only; frameDone one cycle later; frameCount=1; busy=0.
- Backpressure: txReady=0 while 6 pixels are offered. Required: exactly 4 accepted, then inReady=0, and txPixel holds 0x000001 stable. Releasing txReady drains all 12 in order with no loss or duplication.
- Over-supply: inValid held high beyond 12 pixels. Required: the 13th is not accepted (inReady=0 after the 12th) until the next start.
- Abort mid-frame: abort after 5 outputs. Required: next cycle busy=0, txValid=0, no frameDone, frameCount unchanged. A subsequent start and 12 pixels produce a clean frame with txSof on the first pixel.
- Reset mid-frame: rstN low for 1 cycle after 7 pixels. Required: all outputs at reset values immediately, and start is needed again.
- Wrap and ignore: start pulsed during STREAM is ignored. A frame completing with frameCount preloaded (forced) to 65535 leaves frameCount=0.
